// File: rtl/bin2bcd_pkg.sv
// Shared sizing constants, FSM state type and BCD word type for the bin2bcd_blank converter.
package bin2bcd_pkg;

  localparam int unsigned BinWidth   = 14;
  localparam int unsigned NumDigits  = 4;
  localparam int unsigned DigitWidth = 4;
  localparam int unsigned BcdWidth   = NumDigits * DigitWidth;
  localparam int unsigned MaxValue   = 9999;
  localparam int unsigned NumIters   = 14;
  localparam int unsigned CntWidth   = 4;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StDone  = 2'd2
  } state_e;

  typedef logic [BcdWidth-1:0] bcd_t;

endpackage

// File: rtl/bin2bcd_blank_add3.sv
// Double-dabble correction cell: adds 3 to a BCD nibble that is 5 or more.
module bcd_add3 (
  input  logic [3:0] nib,
  output logic [3:0] nib_adj_c
);

  assign nib_adj_c = (nib >= 4'd5) ? (nib + 4'd3) : nib;

endmodule

// File: rtl/bin2bcd_blank.sv
// Sequential 14-bit binary to 4-digit BCD converter with optional leading-zero blanking.
// Blanking is enabled by defining BIN2BCD_LEADING_ZERO_BLANK_EN.
module bin2bcd_blank
  import bin2bcd_pkg::*;
(
  input  logic                clk_1k_i,
  input  logic                rst_ni,
  input  logic                valid_i,
  input  logic [BinWidth-1:0] bin_i,
  output logic                ready_o,
  output logic                done_o,
  output logic                ovf_o,
  output logic [3:0]          digit0_o,
  output logic [3:0]          digit1_o,
  output logic [3:0]          digit2_o,
  output logic [3:0]          digit3_o,
  output logic                digit0_en_o,
  output logic                digit1_en_o,
  output logic                digit2_en_o,
  output logic                digit3_en_o
);

`ifdef BIN2BCD_LEADING_ZERO_BLANK_EN
  localparam logic [NumDigits-1:0] EnReset = NumDigits'(1);
`else
  localparam logic [NumDigits-1:0] EnReset = '1;
`endif

  state_e                state_q, state_d;
  logic [BinWidth-1:0]   shift_q, shift_d;
  bcd_t                  acc_q, acc_d, acc_adj;
  bcd_t                  digits_q, digits_d;
  logic [CntWidth-1:0]   cnt_q, cnt_d;
  logic [NumDigits-1:0]  en_q, en_d, en_load;
  logic                  ovf_q, ovf_d;
  logic                  done_q, done_d;
  logic                  ready_q, ready_d;
  logic                  over_max;

  for (genvar i = 0; i < NumDigits; i++) begin : g_add3
    bcd_add3 u_add3 (
      .nib       (acc_q[i*DigitWidth +: DigitWidth]),
      .nib_adj_c (acc_adj[i*DigitWidth +: DigitWidth])
    );
  end

  // Enables for the finished accumulator: lit from the top nonzero digit down
  always_comb begin
    en_load = '1;
`ifdef BIN2BCD_LEADING_ZERO_BLANK_EN
    en_load[3] = |acc_q[15:12];
    en_load[2] = en_load[3] | (|acc_q[11:8]);
    en_load[1] = en_load[2] | (|acc_q[7:4]);
    en_load[0] = 1'b1;
`endif
  end

  assign over_max = (bin_i > BinWidth'(MaxValue));

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    digits_d = digits_q;
    en_d     = en_q;
    done_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (valid_i && ready_q) begin
          shift_d = over_max ? BinWidth'(MaxValue) : bin_i;
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = over_max;
          state_d = StShift;
        end
      end
      StShift: begin
        acc_d   = {acc_adj[BcdWidth-2:0], shift_q[BinWidth-1]};
        shift_d = {shift_q[BinWidth-2:0], 1'b0};
        cnt_d   = cnt_q + CntWidth'(1);
        if (cnt_q == CntWidth'(NumIters - 1)) begin
          state_d = StDone;
        end
      end
      StDone: begin
        digits_d = acc_q;
        en_d     = en_load;
        done_d   = 1'b1;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
    ready_d = (state_d == StIdle);
  end

  always_ff @(posedge clk_1k_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      shift_q  <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      digits_q <= '0;
      en_q     <= EnReset;
      done_q   <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      digits_q <= digits_d;
      en_q     <= en_d;
      done_q   <= done_d;
      ready_q  <= ready_d;
    end
  end

  assign ready_o     = ready_q;
  assign done_o      = done_q;
  assign ovf_o       = ovf_q;
  assign digit0_o    = digits_q[3:0];
  assign digit1_o    = digits_q[7:4];
  assign digit2_o    = digits_q[11:8];
  assign digit3_o    = digits_q[15:12];
  assign digit0_en_o = en_q[0];
  assign digit1_en_o = en_q[1];
  assign digit2_en_o = en_q[2];
  assign digit3_en_o = en_q[3];

endmodule
